// File: rtl/register_file_q2.sv
// register_file_q2: DEPTH x WIDTH operand register file.
// One write port, two registered read ports, per-entry valid bits and a
// one-entry-per-cycle clear sweep. While a sweep runs, writes are dropped
// and write_drop pulses for one cycle afterwards.
module register_file_q2 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              choice,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_port_1,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic              clear,
  output logic [WIDTH-1:0]  read_port_1,
  output logic [WIDTH-1:0]  read_port_2,
  output logic              read_valid_1,
  output logic              read_valid_2,
  output logic              busy,
  output logic              write_drop
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 2;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                        state, state_nx;
  logic [ADDR_W-1:0]             ptr, ptr_nx;
  logic                          wr_acc, drop_nx;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [DEPTH-1:0]              vld;
  logic [NPORT-1:0][ADDR_W-1:0]  ra;
  logic [NPORT-1:0][WIDTH-1:0]   rd_q;
  logic [NPORT-1:0]              rv_q;
  logic                          drop_q;

  assign ra = {read_addr_2, read_addr_1};

  // State and sweep pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Next state, pointer advance, write accept/drop decision
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    wr_acc   = 1'b0;
    drop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx = SWEEP;
          ptr_nx   = '0;
          drop_nx  = choice;
        end else begin
          wr_acc   = choice;
        end
      end
      SWEEP: begin
        drop_nx = choice;
        ptr_nx  = ptr + 1'b1;  // wraps to 0 after the last entry
        if (ptr == '1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage: accepted writes and sweep zeroing (never in the same cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
      vld <= '0;
    end else begin
      if (wr_acc) begin
        mem[write_addr] <= write_port_1;
        vld[write_addr] <= 1'b1;
      end
      if (state == SWEEP) begin
        mem[ptr] <= '0;
        vld[ptr] <= 1'b0;
      end
    end
  end

  // Registered read ports with write-first and sweep bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      rv_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (wr_acc && write_addr == ra[p]) begin
          rd_q[p] <= write_port_1;
          rv_q[p] <= 1'b1;
        end else if (state == SWEEP && ra[p] == ptr) begin
          rd_q[p] <= '0;
          rv_q[p] <= 1'b0;
        end else begin
          rd_q[p] <= mem[ra[p]];
          rv_q[p] <= vld[ra[p]];
        end
      end
    end
  end

  // Dropped-write pulse
  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= drop_nx;
  end

  assign read_port_1  = rd_q[0];
  assign read_port_2  = rd_q[1];
  assign read_valid_1 = rv_q[0];
  assign read_valid_2 = rv_q[1];
  assign busy         = (state == SWEEP);
  assign write_drop   = drop_q;
endmodule

// File: tb/tb_register_file_q2.sv
// Bench for register_file_q2: directed steps from the test plan followed by
// random traffic, every cycle compared against a behavioural model.
module tb_register_file_q2;
  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset, choice, clear;
  logic [AW-1:0]    write_addr, read_addr_1, read_addr_2;
  logic [WIDTH-1:0] write_port_1, read_port_1, read_port_2;
  logic             read_valid_1, read_valid_2, busy, write_drop;

  int checks = 0;
  int failures = 0;

  // behavioural model: contents, valid bits, and sweep progress
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_val [DEPTH];
  bit               m_sweeping = 0;
  int               m_idx = 0;
  int               busy_run = 0;

  register_file_q2 #(.WIDTH(WIDTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .choice(choice), .write_addr(write_addr),
    .write_port_1(write_port_1), .read_addr_1(read_addr_1),
    .read_addr_2(read_addr_2), .clear(clear), .read_port_1(read_port_1),
    .read_port_2(read_port_2), .read_valid_1(read_valid_1),
    .read_valid_2(read_valid_2), .busy(busy), .write_drop(write_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected read result for one port given the pre-edge model state
  function automatic logic [WIDTH:0] model_read(input bit acc, input int wa,
      input logic [WIDTH-1:0] wd, input int ra);
    if (acc && wa == ra)                return {1'b1, wd};
    else if (m_sweeping && ra == m_idx) return '0;
    else                                return {m_val[ra], m_mem[ra]};
  endfunction

  // One clock: drive, predict, clock, compare
  task automatic cycle(input string tag, input bit rst, input bit ch, input int wa,
      input logic [WIDTH-1:0] wd, input int r1, input int r2, input bit clr);
    logic [WIDTH:0] e1, e2;
    bit acc, drp;
    reset = rst; choice = ch; write_addr = AW'(wa); write_port_1 = wd;
    read_addr_1 = AW'(r1); read_addr_2 = AW'(r2); clear = clr;
    if (rst) begin
      e1 = '0; e2 = '0; drp = 0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_val[i] = 0; end
      m_sweeping = 0; m_idx = 0;
    end else begin
      acc = !m_sweeping && ch && !clr;
      drp = ch && (m_sweeping || clr);
      e1 = model_read(acc, wa, wd, r1);
      e2 = model_read(acc, wa, wd, r2);
      if (acc) begin m_mem[wa] = wd; m_val[wa] = 1; end
      if (m_sweeping) begin
        m_mem[m_idx] = '0; m_val[m_idx] = 0;
        if (m_idx == DEPTH-1) begin m_sweeping = 0; m_idx = 0; end
        else m_idx++;
      end else if (clr) begin
        m_sweeping = 1; m_idx = 0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".rd1"},  read_port_1,  e1[WIDTH-1:0]);
    chk({tag, ".rd2"},  read_port_2,  e2[WIDTH-1:0]);
    chk({tag, ".rv1"},  read_valid_1, e1[WIDTH]);
    chk({tag, ".rv2"},  read_valid_2, e2[WIDTH]);
    chk({tag, ".busy"}, busy,         m_sweeping);
    chk({tag, ".drop"}, write_drop,   drp);
    busy_run = busy ? busy_run + 1 : 0;
  endtask

  task automatic idle(input string tag, input int r1, input int r2);
    cycle(tag, 0, 0, 0, 0, r1, r2, 0);
  endtask

  initial begin
    int bmax;
    // reset state
    cycle("reset", 1, 0, 0, 0, 0, 0, 0);
    cycle("reset2", 1, 1, 1, 16'hFFFF, 1, 1, 1);
    // basic writes and reads
    cycle("wr65", 0, 1, 1, 65, 0, 0, 0);
    cycle("wr241", 0, 1, 3, 241, 1, 3, 0);
    idle("rd13", 1, 3);
    chk("rd13.lit1", read_port_1, 65);
    chk("rd13.lit2", read_port_2, 241);
    idle("rd5", 5, 5);
    // write-first bypass, then a no-write cycle
    cycle("byp73", 0, 1, 2, 73, 2, 2, 0);
    chk("byp73.lit", read_port_1, 73);
    cycle("nowr32", 0, 0, 1, 32, 1, 2, 0);
    idle("rd1", 1, 2);
    chk("rd1.lit", read_port_1, 65);
    // fill, sweep, drop a write mid-sweep, verify busy length
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, i, WIDTH'($urandom), i, 7 - i, 0);
    cycle("clr", 0, 0, 0, 0, 0, 1, 1);
    bmax = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 2) cycle("sw123", 0, 1, 6, 123, 6, i, 0);
      else        cycle("sweep", 0, 0, 0, 0, i, (i + 1) % DEPTH, 0);
      if (busy_run > bmax) bmax = busy_run;
    end
    chk("busy_len", bmax, DEPTH);
    for (int i = 0; i < DEPTH; i++) idle("postclr", i, 7 - i);
    // reset during sweep cycle 3
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 0, 1, i, WIDTH'(i + 10), i, i, 0);
    cycle("clr2", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle("sweep2", i, 4);
    cycle("midrst", 1, 0, 0, 0, 4, 4, 0);
    cycle("wr93", 0, 1, 4, 93, 0, 1, 0);
    idle("rd93", 4, 4);
    chk("rd93.lit", read_port_1, 93);
    // clear and write together
    cycle("wr0", 0, 1, 0, 500, 0, 0, 0);
    cycle("clrwr", 0, 1, 0, 256, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) idle("sweep3", 0, i);
    idle("rd0", 0, 0);
    // random traffic
    for (int n = 0; n < 600; n++)
      cycle("rand", $urandom_range(49) == 0, $urandom_range(1),
            $urandom_range(DEPTH-1), WIDTH'($urandom),
            $urandom_range(DEPTH-1), $urandom_range(DEPTH-1),
            $urandom_range(15) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
